// File: rtl/posit_defines.sv
// Shared posit format constants and the decoded-value record passed to the accumulator.
package posit_defines;

  localparam int NBITS   = 32;
  localparam int ES      = 2;
  // Signed scale wide enough for regime * 2^ES + exponent at any regime length.
  localparam int SCALE_W = $clog2(NBITS) + ES + 2;
  // Fraction bits left over when the regime is at its shortest (2 bits).
  localparam int FRAC_W  = NBITS - ES - 3;

  typedef struct packed {
    logic                      sgn;
    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]         fraction;
    logic                      inf;
    logic                      zero;
  } value_accum;

endpackage

// File: rtl/posit_extract_accum.sv
// Combinational posit decoder: sign, regime+exponent scale, MSB-aligned fraction, specials.
module posit_extract_accum
  import posit_defines::*;
(
  input  logic [NBITS-1:0] posit,
  output value_accum       value,
  output logic [NBITS-2:0] mag
);

  localparam int RUN_W  = $clog2(NBITS) + 1;
  localparam int TAIL_W = ES + FRAC_W;

  logic [NBITS-2:0]          body;
  logic [RUN_W-1:0]          run;
  logic                      run_done;
  logic signed [SCALE_W-1:0] run_ext;
  logic signed [SCALE_W-1:0] regime;
  logic [TAIL_W-1:0]         tail;
  logic [ES-1:0]             exp_bits;

  // Decode magnitude, regime run length, exponent and fraction; specials override.
  always_comb begin
    body     = posit[NBITS-1] ? (~posit[NBITS-2:0] + 1'b1) : posit[NBITS-2:0];
    run      = '0;
    run_done = 1'b0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!run_done && (body[i] == body[NBITS-2])) begin
        run = run + 1'b1;
      end else begin
        run_done = 1'b1;
      end
    end
    run_ext  = {{(SCALE_W-RUN_W){1'b0}}, run};
    regime   = body[NBITS-2] ? (run_ext - SCALE_W'(1)) : (-run_ext);
    // Drop the regime run and its terminator; keep the top exponent+fraction bits.
    tail     = TAIL_W'((body << (run + 1'b1)) >> (NBITS - 1 - TAIL_W));
    exp_bits = tail[TAIL_W-1 -: ES];
    value     = '0;
    value.sgn = posit[NBITS-1];
    if (posit == {NBITS{1'b0}}) begin
      value.zero = 1'b1;
    end else if (posit == {1'b1, {(NBITS-1){1'b0}}}) begin
      value.inf = 1'b1;
    end else begin
      value.scale    = (regime <<< ES) + {{(SCALE_W-ES){1'b0}}, exp_bits};
      value.fraction = tail[FRAC_W-1:0];
    end
    mag = body;
  end

endmodule

// File: rtl/posit_rr_arbiter.sv
// Round-robin pick: first asserted request searching from ptr upward, wrapping mod NREQ.
module posit_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_valid
);

  // Scan requesters in priority order starting at ptr; first hit wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      int  idx;
      logic hit;
      idx         = (int'(ptr) + off) % NREQ;
      hit         = !grant_valid & req[idx];
      grant_idx   = hit ? ID_W'(idx) : grant_idx;
      grant_valid = grant_valid | hit;
    end
  end

endmodule

// File: rtl/posit_extract_sched.sv
// Burst-locked round-robin scheduler sharing one posit decoder across NREQ streams,
// with a two-stage valid/ready pipeline around the decoder.
module posit_extract_sched
  import posit_defines::*;
#(
  parameter  int NREQ   = 4,
  parameter  int BEAT_W = 8,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*NBITS-1:0] in_data,
  input  logic [NREQ-1:0]       in_last,
  output logic [NREQ-1:0]       in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output value_accum            out_value,
  output logic [NBITS-2:0]      out_abs,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_last,
  output logic [BEAT_W-1:0]     out_beat
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   lock, lock_next;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_next;
  logic [BEAT_W-1:0] beat;
  logic [ID_W-1:0]   arb_idx, grant_idx;
  logic              arb_valid, grant_valid;
  logic              s1_free, s2_free, accept, sel_last;
  logic [NBITS-1:0]  sel_data;
  logic              s1_valid, s1_last;
  logic [NBITS-1:0]  s1_posit;
  logic [ID_W-1:0]   s1_id;
  logic [BEAT_W-1:0] s1_beat;
  value_accum        dec_value;
  logic [NBITS-2:0]  dec_mag;

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return (p == ID_W'(NREQ - 1)) ? '0 : (p + 1'b1);
  endfunction

  posit_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  posit_extract_accum u_dec (
    .posit(s1_posit),
    .value(dec_value),
    .mag  (dec_mag)
  );

  // Grant selection, per-requester ready and the accepted beat's payload.
  always_comb begin
    s2_free = !out_valid | out_ready;
    s1_free = !s1_valid | s2_free;
    if (state == BURST) begin
      grant_idx   = lock;
      grant_valid = 1'b1;
    end else begin
      grant_idx   = arb_idx;
      grant_valid = arb_valid;
    end
    for (int i = 0; i < NREQ; i++) begin
      in_ready[i] = !reset & s1_free & grant_valid & (grant_idx == ID_W'(i));
    end
    accept   = |(in_valid & in_ready);
    sel_data = in_data[int'(grant_idx)*NBITS +: NBITS];
    sel_last = in_last[grant_idx];
  end

  // Next-state logic: lock on a multi-beat burst, advance the pointer past its owner on last.
  always_comb begin
    state_next  = state;
    lock_next   = lock;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (accept && sel_last) begin
          rr_ptr_next = ptr_inc(grant_idx);
        end else if (accept) begin
          state_next = BURST;
          lock_next  = grant_idx;
        end else begin
          state_next = IDLE;
        end
      end
      BURST: begin
        if (accept && sel_last) begin
          state_next  = IDLE;
          rr_ptr_next = ptr_inc(lock);
        end else begin
          state_next = BURST;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbitration state and beat-within-burst counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lock   <= '0;
      rr_ptr <= '0;
      beat   <= '0;
    end else begin
      state  <= state_next;
      lock   <= lock_next;
      rr_ptr <= rr_ptr_next;
      if (accept) begin
        beat <= sel_last ? '0 : (beat + 1'b1);
      end
    end
  end

  // Stage 1: capture the accepted raw posit and its tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_posit <= '0;
      s1_id    <= '0;
      s1_last  <= 1'b0;
      s1_beat  <= '0;
    end else if (s1_free) begin
      s1_valid <= accept;
      if (accept) begin
        s1_posit <= sel_data;
        s1_id    <= grant_idx;
        s1_last  <= sel_last;
        s1_beat  <= beat;
      end
    end
  end

  // Stage 2: capture the decoded value; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_abs   <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
      out_beat  <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_value <= dec_value;
        out_abs   <= dec_mag;
        out_id    <= s1_id;
        out_last  <= s1_last;
        out_beat  <= s1_beat;
      end
    end
  end

endmodule

// File: tb/tb_posit_extract_sched.sv
// Bench for posit_extract_sched: directed scenarios plus random traffic, all checked
// against a transaction-level model (owner/pointer arbitration, aging pipeline queue,
// bit-serial posit decode).
module tb_posit_extract_sched;
  import posit_defines::*;

  localparam int NREQ   = 4;
  localparam int BEAT_W = 8;
  localparam int ID_W   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       in_valid, in_last, in_ready;
  logic [NREQ*NBITS-1:0] in_data;
  logic                  out_valid, out_ready;
  value_accum            out_value;
  logic [NBITS-2:0]      out_abs;
  logic [ID_W-1:0]       out_id;
  logic                  out_last;
  logic [BEAT_W-1:0]     out_beat;

  always #5 clk = ~clk;

  posit_extract_sched #(.NREQ(NREQ), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_abs(out_abs), .out_id(out_id), .out_last(out_last), .out_beat(out_beat)
  );

  typedef struct { logic [31:0] data; logic last; } beat_t;
  typedef struct { logic [31:0] posit; int id; logic last; int beat; int age; } item_t;

  beat_t plan[NREQ][$];
  item_t pipe[$];
  int    owner, ptr, mbeat, bubble_pct, acc_g;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input logic [30:0] a, input int pos);
    if (pos < 0) return 1'b0;
    return a[pos];
  endfunction

  function automatic logic [30:0] ref_mag(input logic [31:0] p);
    logic [31:0] a;
    a = p[31] ? (32'd0 - p) : p;
    return a[30:0];
  endfunction

  // Posit value = (-1)^s * 2^(k*2^ES + e) * 1.f, read bit by bit after the sign.
  function automatic value_accum ref_decode(input logic [31:0] p);
    value_accum        v;
    logic [30:0]       a;
    logic              r0;
    logic [FRAC_W-1:0] f;
    int pos, run, k, e;
    v = '0;
    if (p == 32'h0000_0000) begin v.zero = 1'b1; return v; end
    if (p == 32'h8000_0000) begin v.inf = 1'b1; v.sgn = 1'b1; return v; end
    v.sgn = p[31];
    a = ref_mag(p);
    r0 = a[30]; pos = 30; run = 0;
    while (pos >= 0) begin
      if (a[pos] != r0) break;
      run++; pos--;
    end
    k = r0 ? (run - 1) : -run;
    pos--;
    e = 0;
    for (int j = 0; j < ES; j++) begin e = e * 2 + int'(bit_at(a, pos)); pos--; end
    f = '0;
    for (int j = 0; j < FRAC_W; j++) begin f = {f[FRAC_W-2:0], bit_at(a, pos)}; pos--; end
    v.scale    = SCALE_W'(k * (1 << ES) + e);
    v.fraction = f;
    return v;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (!in_valid[i] && plan[i].size() > 0 && $urandom_range(99) >= bubble_pct) in_valid[i] = 1'b1;
      if (in_valid[i]) begin
        in_data[i*NBITS +: NBITS] = plan[i][0].data;
        in_last[i] = plan[i][0].last;
      end else begin
        in_data[i*NBITS +: NBITS] = $urandom;
        in_last[i] = 1'($urandom_range(1));
      end
    end
  endtask

  // One clock: drive, check against the model, advance model at the edge.
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_ready;
    logic exp_ov, pop, rst_now, s1free;
    item_t it;
    drive();
    #1;
    g = -1;
    if (owner >= 0) g = owner;
    else for (int off = 0; off < NREQ; off++) begin
      if (g < 0 && in_valid[(ptr + off) % NREQ]) g = (ptr + off) % NREQ;
    end
    s1free = (pipe.size() < 2) || out_ready;
    exp_ready = '0;
    if (!reset && g >= 0 && s1free) exp_ready[g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    exp_ov = (pipe.size() > 0) && (pipe[0].age >= 2);
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      chk("out_id", 64'(out_id), 64'(pipe[0].id));
      chk("out_last", 64'(out_last), 64'(pipe[0].last));
      chk("out_beat", 64'(out_beat), 64'(pipe[0].beat % 256));
      chk("out_value", 64'(out_value), 64'(ref_decode(pipe[0].posit)));
      chk("out_abs", 64'(out_abs), 64'(ref_mag(pipe[0].posit)));
    end
    pop = exp_ov && out_ready;
    acc_g = (g >= 0 && exp_ready[g] && in_valid[g]) ? g : -1;
    rst_now = reset;
    @(posedge clk);
    if (rst_now) begin
      pipe.delete(); owner = -1; ptr = 0; mbeat = 0; acc_g = -1;
    end else begin
      if (pop) void'(pipe.pop_front());
      for (int j = 0; j < pipe.size(); j++) pipe[j].age = pipe[j].age + 1;
      if (acc_g >= 0) begin
        it.posit = plan[acc_g][0].data; it.id = acc_g; it.last = plan[acc_g][0].last;
        it.beat = mbeat; it.age = 1;
        pipe.push_back(it);
        mbeat = plan[acc_g][0].last ? 0 : mbeat + 1;
        if (plan[acc_g][0].last) begin owner = -1; ptr = (acc_g + 1) % NREQ; end
        else owner = acc_g;
      end
    end
    @(negedge clk);
    if (rst_now) begin
      for (int i = 0; i < NREQ; i++) plan[i].delete();
      in_valid = '0;
    end else if (acc_g >= 0) begin
      void'(plan[acc_g].pop_front());
      in_valid[acc_g] = 1'b0;
    end
  endtask

  task automatic push_burst(input int r, input int n, input logic [31:0] first);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.data = (j == 0) ? first : $urandom;
      b.last = (j == n - 1);
      plan[r].push_back(b);
    end
  endtask

  task automatic push_beat(input int r, input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l;
    plan[r].push_back(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; out_ready = 1'b1; in_valid = '0; in_last = '0; in_data = '0;
    bubble_pct = 0; owner = -1; ptr = 0; mbeat = 0; acc_g = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();
    chk("rst_value", 64'(out_value), 64'd0);
    chk("rst_abs", 64'(out_abs), 64'd0);
    chk("rst_id_last_beat", 64'({out_id, out_last, out_beat}), 64'd0);

    // Single beat from requester 0.
    push_beat(0, 32'h4000_0000, 1'b1);
    repeat (4) step();

    // Requester 0 three-beat burst holds off requester 2.
    do_reset();
    push_beat(0, 32'h4000_0000, 1'b0);
    push_beat(0, 32'h4800_0000, 1'b0);
    push_beat(0, 32'hC000_0000, 1'b1);
    push_beat(2, 32'h5000_0000, 1'b1);
    repeat (8) step();

    // All four requesters with continuous single-beat bursts.
    for (int k = 0; k < 3; k++) for (int r = 0; r < NREQ; r++) push_burst(r, 1, $urandom);
    repeat (16) step();

    // Backpressure for 5 cycles during a 4-beat burst.
    push_burst(1, 4, 32'h3000_0000);
    step();
    out_ready = 1'b0;
    repeat (5) step();
    out_ready = 1'b1;
    repeat (8) step();

    // Special encodings.
    push_beat(3, 32'h0000_0000, 1'b1);
    push_beat(3, 32'h8000_0000, 1'b1);
    repeat (5) step();

    // Reset mid-burst with both stages full, then requester 0 must win.
    push_burst(1, 4, 32'h6000_0000);
    out_ready = 1'b0;
    repeat (4) step();
    do_reset();
    out_ready = 1'b1;
    push_beat(3, 32'h2000_0000, 1'b1);
    push_beat(0, 32'h1000_0000, 1'b1);
    repeat (6) step();

    // Random traffic with bubbles and backpressure.
    bubble_pct = 30;
    for (int c = 0; c < 800; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (plan[r].size() == 0 && $urandom_range(99) < 40) begin
          case ($urandom_range(9))
            0: push_burst(r, $urandom_range(1, 5), 32'h0000_0000);
            1: push_burst(r, $urandom_range(1, 5), 32'h8000_0000);
            2: push_burst(r, $urandom_range(1, 5), 32'h7FFF_FFFF);
            default: push_burst(r, $urandom_range(1, 5), $urandom);
          endcase
        end
      end
      out_ready = ($urandom_range(99) < 75);
      step();
    end

    // Drain everything still planned or in flight.
    bubble_pct = 0; out_ready = 1'b1; guard = 0;
    while ((pipe.size() > 0 || plan[0].size() > 0 || plan[1].size() > 0 ||
            plan[2].size() > 0 || plan[3].size() > 0) && guard < 300) begin
      step();
      guard++;
    end
    chk("drain_timeout", 64'(guard < 300), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
